// File: rtl/string_hw_sequencer_pkg.sv
// Shared definitions for the string accelerator sequencer: operation codes,
// accelerator register map, control-word layout and sequencer states.
package string_hw_pkg;

    typedef enum logic [2:0] {
        OP_CMP   = 3'd0,
        OP_UPPER = 3'd1,
        OP_LOWER = 3'd2
    } op_e;

    localparam logic [2:0] REG_A      = 3'd0;
    localparam logic [2:0] REG_B      = 3'd1;
    localparam logic [2:0] REG_CTL    = 3'd2;
    localparam logic [2:0] REG_RESULT = 3'd3;

    localparam int CTL_DONE    = 0;
    localparam int CTL_GO      = 1;
    localparam int CTL_IDX_LSB = 2;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_A    = 4'd1,
        ST_WR_B    = 4'd2,
        ST_WR_GO   = 4'd3,
        ST_RD_CTL  = 4'd4,
        ST_CHK_CTL = 4'd5,
        ST_RD_RES  = 4'd6,
        ST_CAP_RES = 4'd7,
        ST_CLR_GO  = 4'd8,
        ST_RESP    = 4'd9
    } state_e;

    // Control word: index in [4:2], go in bit 1, done (read-only) in bit 0.
    function automatic logic [31:0] ctl_word(input logic [2:0] idx, input logic go);
        logic [31:0] w;
        w = '0;
        w[CTL_IDX_LSB +: 3] = idx;
        w[CTL_GO]           = go;
        return w;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_LOWER;
    endfunction

endpackage

// File: rtl/string_hw_sequencer_if.sv
// Command/response handshake plus Avalon-MM master bus of the sequencer.
// The sequencer uses the master modport; the command source, response sink
// and accelerator slave together use the slave modport.
interface string_hw_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        m_chipselect;
    logic        m_write;
    logic        m_read;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, m_readdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
               m_chipselect, m_write, m_read, m_address, m_writedata
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, m_readdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
               m_chipselect, m_write, m_read, m_address, m_writedata
    );
endinterface

// File: rtl/string_hw_sequencer.sv
// Drives a memory-mapped string accelerator through one command:
// load A and B, set go, poll done (bounded), fetch result, clear go, respond.
// All bus outputs are registered and derived from the next state so that a
// strobe is high exactly while the FSM sits in the matching state.
module string_hw_sequencer
    import string_hw_pkg::*;
#(
    parameter int POLL_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    string_hw_sequencer_if.master bus
);

    localparam int CW = $clog2(POLL_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(POLL_LIMIT);

    localparam logic [3:0] IDLE    = ST_IDLE;
    localparam logic [3:0] WR_A    = ST_WR_A;
    localparam logic [3:0] WR_B    = ST_WR_B;
    localparam logic [3:0] WR_GO   = ST_WR_GO;
    localparam logic [3:0] RD_CTL  = ST_RD_CTL;
    localparam logic [3:0] CHK_CTL = ST_CHK_CTL;
    localparam logic [3:0] RD_RES  = ST_RD_RES;
    localparam logic [3:0] CAP_RES = ST_CAP_RES;
    localparam logic [3:0] CLR_GO  = ST_CLR_GO;
    localparam logic [3:0] RESP    = ST_RESP;

    logic [3:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   b_q, b_d;
    logic [CW-1:0] poll_q, poll_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          cs_q, cs_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [2:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          accept;

    assign accept = (state_q == IDLE) && bus.cmd_valid;

    // Next-state logic of the command sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.cmd_valid) state_d = op_legal(bus.cmd_op) ? WR_A : RESP;
            WR_A:    state_d = WR_B;
            WR_B:    state_d = WR_GO;
            WR_GO:   state_d = RD_CTL;
            RD_CTL:  state_d = CHK_CTL;
            CHK_CTL: begin
                if (bus.m_readdata[CTL_DONE])  state_d = RD_RES;
                else if (poll_q < LIMIT_C)     state_d = RD_CTL;
                else                           state_d = CLR_GO;
            end
            RD_RES:  state_d = CAP_RES;
            CAP_RES: state_d = CLR_GO;
            CLR_GO:  state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command latching, poll counting and response bookkeeping.
    always_comb begin
        op_d        = op_q;
        b_d         = b_q;
        poll_d      = poll_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = (state_d == RESP);
        if (accept) begin
            op_d       = bus.cmd_op;
            b_d        = bus.cmd_b;
            poll_d     = '0;
            rsp_data_d = '0;
            rsp_err_d  = !op_legal(bus.cmd_op);
        end
        if (state_q == RD_CTL && poll_q < LIMIT_C)
            poll_d = poll_q + 1'b1;
        if (state_q == CHK_CTL && state_d == CLR_GO)
            rsp_err_d = 1'b1;
        if (state_q == CAP_RES)
            rsp_data_d = bus.m_readdata;
    end

    // Bus strobes, address and write data for the state being entered.
    // String A goes straight from the command port into the write-data
    // register on acceptance, so it needs no separate holding register.
    always_comb begin
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_d)
            WR_A: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = REG_A; wdata_d = bus.cmd_a;
            end
            WR_B: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = REG_B; wdata_d = b_q;
            end
            WR_GO: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = REG_CTL; wdata_d = ctl_word(op_q, 1'b1);
            end
            CLR_GO: begin
                cs_d = 1'b1; wr_d = 1'b1; addr_d = REG_CTL; wdata_d = ctl_word(op_q, 1'b0);
            end
            RD_CTL: begin
                cs_d = 1'b1; rd_d = 1'b1; addr_d = REG_CTL;
            end
            RD_RES: begin
                cs_d = 1'b1; rd_d = 1'b1; addr_d = REG_RESULT;
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            b_q         <= '0;
            poll_q      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            b_q         <= b_d;
            poll_q      <= poll_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.cmd_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.m_chipselect = cs_q;
    assign bus.m_write      = wr_q;
    assign bus.m_read       = rd_q;
    assign bus.m_address    = addr_q;
    assign bus.m_writedata  = wdata_q;

endmodule
